// File: rtl/ctrl_pkg.sv
// Shared control-word definitions for the ALU/accumulator datapath and the
// state encoding of the ROM sequencer.
`default_nettype none

package ctrl_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  localparam int ALU_SEL_HI = 3;
  localparam int ALU_SEL_LO = 2;
  localparam int MUX_SEL    = 1;
  localparam int LOAD       = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } seq_state_e;

endpackage : ctrl_pkg

`default_nettype wire

// File: rtl/rom_sequencer.sv
// ---------------------------------------------------------------------------
// rom_sequencer : walks the control ROM from address 0 to LAST_ADDR per start
//                 request and registers each control word onto the datapath.
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rom_sequencer #(
  parameter int ADDR_W    = 3,
  parameter int LAST_ADDR = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  input  logic [3:0]        rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [1:0]        alu_sel,
  output logic              mux_sel,
  output logic              load,
  output logic              busy,
  output logic              done
);

  import ctrl_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  generate
    if (LAST_ADDR > (2 ** ADDR_W) - 1 || LAST_ADDR < 0) begin : g_last_addr_check
      $error("rom_sequencer: LAST_ADDR does not fit in ADDR_W bits");
    end
  endgenerate

  seq_state_e        state_q,    state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [1:0]        alu_sel_q,  alu_sel_d;
  logic              mux_sel_q,  mux_sel_d;
  logic              load_q,     load_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    alu_sel_d  = alu_sel_q;
    mux_sel_d  = mux_sel_q;
    load_d     = load_q;

    case (state_q)
      ST_IDLE: begin
        rom_addr_d = '0;
        load_d     = 1'b0;
        if (start) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (hold) begin
          // Bubble: address frozen so the same word is re-fetched later.
          load_d = 1'b0;
        end else begin
          alu_sel_d = rom_data[ALU_SEL_HI:ALU_SEL_LO];
          mux_sel_d = rom_data[MUX_SEL];
          load_d    = rom_data[LOAD];
          if (rom_addr_q == LAST) begin
            state_d    = ST_TAIL;
            rom_addr_d = '0;
          end else begin
            rom_addr_d = rom_addr_q + 1'b1;
          end
        end
      end

      ST_TAIL: begin
        state_d = ST_IDLE;
        load_d  = 1'b0;
      end

      default: begin
        state_d    = ST_IDLE;
        rom_addr_d = '0;
        load_d     = 1'b0;
      end
    endcase

    // Status flags follow the next state so they line up with the outputs.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_TAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      alu_sel_q  <= 2'b00;
      mux_sel_q  <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      alu_sel_q  <= alu_sel_d;
      mux_sel_q  <= mux_sel_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign alu_sel  = alu_sel_q;
  assign mux_sel  = mux_sel_q;
  assign load     = load_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule : rom_sequencer

`default_nettype wire

// File: tb/tb_rom_sequencer.sv
// Scoreboard bench: two sequencers (LAST_ADDR 6 and 7) share stimulus and a
// production ROM model; a run-plan reference model predicts every cycle.
`default_nettype none

module tb_rom_sequencer;

  logic clk = 1'b0;
  logic rst, start, hold;

  logic [2:0] addr0, addr1;
  logic [3:0] data0, data1;
  logic [1:0] alu0, alu1;
  logic       mux0, mux1, load0, load1, busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  function automatic logic [3:0] rom_word(input logic [2:0] a);
    case (a)
      3'd0:    rom_word = 4'b0001;
      3'd1:    rom_word = 4'b0101;
      3'd2:    rom_word = 4'b1001;
      3'd3:    rom_word = 4'b1101;
      3'd4:    rom_word = 4'b1111;
      3'd5:    rom_word = 4'b1111;
      3'd6:    rom_word = 4'b1111;
      default: rom_word = 4'b0000;
    endcase
  endfunction

  assign data0 = rom_word(addr0);
  assign data1 = rom_word(addr1);

  rom_sequencer #(.ADDR_W(3), .LAST_ADDR(6)) dut0 (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .rom_data(data0),
    .rom_addr(addr0), .alu_sel(alu0), .mux_sel(mux0), .load(load0),
    .busy(busy0), .done(done0)
  );

  rom_sequencer #(.ADDR_W(3), .LAST_ADDR(7)) dut1 (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .rom_data(data1),
    .rom_addr(addr1), .alu_sel(alu1), .mux_sel(mux1), .load(load1),
    .busy(busy1), .done(done1)
  );

  typedef struct packed {
    logic [2:0] addr;
    logic [1:0] alu;
    logic       mux;
    logic       load;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct packed {
    int   cyc;
    int   cfg;
    obs_t o;
  } sb_t;

  obs_t act0, act1;
  assign act0 = {addr0, alu0, mux0, load0, busy0, done0};
  assign act1 = {addr1, alu1, mux1, load1, busy1, done1};

  sb_t sbq[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  // Reference model: a run is a list of ROM addresses still to be consumed.
  int   plan   [2][0:8];
  int   rd     [2];
  int   n_left [2];
  bit   tail   [2];
  obs_t m      [2];
  int   last_of[2];

  task automatic model_step(input int c, input bit r, input bit s, input bit h);
    logic [3:0] w;
    if (r) begin
      n_left[c] = 0;
      tail[c]   = 1'b0;
      m[c]      = '0;
    end else begin
      m[c].done = 1'b0;
      if (tail[c]) begin
        tail[c]   = 1'b0;
        m[c].load = 1'b0;
        m[c].busy = 1'b0;
      end else if (n_left[c] == 0) begin
        m[c].load = 1'b0;
        m[c].busy = 1'b0;
        if (s) begin
          for (int i = 0; i <= last_of[c]; i++) plan[c][i] = i;
          rd[c]     = 0;
          n_left[c] = last_of[c] + 1;
          m[c].busy = 1'b1;
        end
      end else begin
        m[c].busy = 1'b1;
        if (h) begin
          m[c].load = 1'b0;
        end else begin
          w         = rom_word(3'(plan[c][rd[c]]));
          rd[c]     = rd[c] + 1;
          n_left[c] = n_left[c] - 1;
          m[c].alu  = w[3:2];
          m[c].mux  = w[1];
          m[c].load = w[0];
          if (n_left[c] == 0) begin
            tail[c]   = 1'b1;
            m[c].done = 1'b1;
          end
        end
      end
    end
    m[c].addr = (n_left[c] != 0) ? 3'(plan[c][rd[c]]) : 3'd0;
  endtask

  task automatic apply(input bit r, input bit s, input bit h);
    sb_t e;
    rst   = r;
    start = s;
    hold  = h;
    for (int c = 0; c < 2; c++) begin
      model_step(c, r, s, h);
      e.cyc = cyc + 1;
      e.cfg = c;
      e.o   = m[c];
      sbq.push_back(e);
    end
    @(posedge clk);
    cyc = cyc + 1;
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) apply(1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    sb_t  e;
    obs_t a;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      a = (e.cfg == 0) ? act0 : act1;
      vectors = vectors + 1;
      if (a !== e.o || e.cyc != cyc) begin
        miscompares = miscompares + 1;
        $display("FAIL outputs last%0d cyc %0d: got addr=%0d alu=%b mux=%b load=%b busy=%b done=%b, expected addr=%0d alu=%b mux=%b load=%b busy=%b done=%b",
                 e.cfg + 6, cyc, a.addr, a.alu, a.mux, a.load, a.busy, a.done,
                 e.o.addr, e.o.alu, e.o.mux, e.o.load, e.o.busy, e.o.done);
      end
    end
  end

  initial begin
    last_of[0] = 6;
    last_of[1] = 7;
    for (int c = 0; c < 2; c++) begin
      rd[c] = 0; n_left[c] = 0; tail[c] = 1'b0; m[c] = '0;
    end
    rst = 1'b1; start = 1'b0; hold = 1'b0;

    repeat (3) apply(1'b1, 1'b0, 1'b0);

    // Plain run.
    apply(1'b0, 1'b1, 1'b0);
    idle(12);

    // Hold in cycles 3-4 of the run.
    apply(1'b0, 1'b1, 1'b0);
    idle(2);
    apply(1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b1);
    idle(12);

    // Start held: back-to-back runs.
    repeat (25) apply(1'b0, 1'b1, 1'b0);
    idle(12);

    // Reset mid-run, then a fresh run.
    apply(1'b0, 1'b1, 1'b0);
    idle(4);
    apply(1'b1, 1'b0, 1'b0);
    idle(3);
    apply(1'b0, 1'b1, 1'b0);
    idle(12);

    // Reset and start together.
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b0);
    idle(12);

    // Hold while idle and in the tail must be ignored.
    apply(1'b0, 1'b1, 1'b1);
    repeat (12) apply(1'b0, 1'b0, ($urandom_range(0, 1) == 1));

    for (int i = 0; i < 1500; i++) begin
      apply(($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 25));
    end
    idle(3);

    rst = 1'b0; start = 1'b0; hold = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc = cyc + 1;
    end
    #1;
    vectors = vectors + 1;
    if (sbq.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_rom_sequencer

`default_nettype wire
